// File: rtl/multi_issue_type_sort.sv
// Multi-issue type sorter: routes a bundle of renamed ops into registered ALU / MEM / TERM issue lanes,
// keeping program order within each class, with optional contiguous-prefix (in-order) consumption.
module multi_issue_type_sort #(
    parameter int FETCH_WIDTH = 4,
    parameter int OP_W        = 47,
    parameter int ALU_LANES   = 2,
    parameter int MEM_LANES   = 1,
    parameter int TERM_LANES  = 1,
    parameter int IN_ORDER    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [FETCH_WIDTH*OP_W-1:0] instr_in,
    input  logic [FETCH_WIDTH-1:0]      instr_valid,
    output logic [FETCH_WIDTH-1:0]      instr_used,
    output logic [ALU_LANES*OP_W-1:0]   alu_op,
    output logic [ALU_LANES-1:0]        alu_valid,
    input  logic [ALU_LANES-1:0]        alu_ready,
    output logic [MEM_LANES*OP_W-1:0]   mem_op,
    output logic [MEM_LANES-1:0]        mem_valid,
    input  logic [MEM_LANES-1:0]        mem_ready,
    output logic [TERM_LANES*OP_W-1:0]  term_op,
    output logic [TERM_LANES-1:0]       term_valid,
    input  logic [TERM_LANES-1:0]       term_ready,
    output logic                        terminate
);
    localparam int NUM_LANES = ALU_LANES + MEM_LANES + TERM_LANES;
    localparam int MEM_BASE  = ALU_LANES;
    localparam int TERM_BASE = ALU_LANES + MEM_LANES;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_MEM  = 2'd1;
    localparam logic [1:0] CLS_TERM = 2'd2;

    generate
        if (TERM_LANES != 1) begin : g_term_lanes_check
            $error("multi_issue_type_sort: only TERM_LANES = 1 is supported");
        end
    endgenerate

    function automatic logic [1:0] lane_cls(input int l);
        if (l < MEM_BASE)       return CLS_ALU;
        else if (l < TERM_BASE) return CLS_MEM;
        else                    return CLS_TERM;
    endfunction

    logic [OP_W-1:0]        slot_op  [FETCH_WIDTH];
    logic [1:0]             slot_cls [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] slot_nop;

    logic [NUM_LANES-1:0]   lane_ready;
    logic [NUM_LANES-1:0]   lane_free;
    logic [NUM_LANES-1:0]   lane_load;
    logic [NUM_LANES-1:0]   lane_valid_q, lane_valid_d;
    logic [OP_W-1:0]        lane_op_q [NUM_LANES];
    logic [OP_W-1:0]        lane_op_d [NUM_LANES];
    logic                   terminate_q, terminate_d;

    // Opcode occupies the top 4 bits, the destination field the 10 bits below it.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_op[i] = instr_in[i*OP_W +: OP_W];
            if (slot_op[i][OP_W-1 -: 2] != 2'b11) slot_cls[i] = CLS_ALU;
            else if (!slot_op[i][OP_W-3])         slot_cls[i] = CLS_MEM;
            else                                  slot_cls[i] = CLS_TERM;
            slot_nop[i] = (slot_cls[i] == CLS_ALU) && (slot_op[i][OP_W-5 -: 10] == 10'd0);
        end
    end

    assign lane_ready = {term_ready, mem_ready, alu_ready};
    assign lane_free  = ~lane_valid_q | lane_ready;

    // NOTE: blocking assignments are correct here: the scan walks the slots in order and each
    // step must see the counters updated by the previous one within the same evaluation.
    always_comb begin
        int   cap  [3];
        int   cnt  [3];
        int   rank [NUM_LANES];
        logic stopped;
        logic blocked;
        logic take;

        // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
        cap         = '{default: 0};
        cnt         = '{default: 0};
        stopped     = 1'b0;
        blocked     = 1'b0;
        take        = 1'b0;
        instr_used  = '0;
        lane_load   = '0;
        lane_op_d   = lane_op_q;
        terminate_d = 1'b0;

        // rank[l] = position of lane l among the free lanes of its class
        for (int l = 0; l < NUM_LANES; l++) begin
            rank[l] = cap[lane_cls(l)];
            if (lane_free[l]) cap[lane_cls(l)] += 1;
        end

        for (int i = 0; i < FETCH_WIDTH; i++) begin
            take = 1'b0;
            if (rst_n && !flush && instr_valid[i] && !stopped) begin
                if (IN_ORDER == 0 || !blocked) begin
                    if (slot_nop[i]) begin
                        take = 1'b1;
                    end else if (cnt[slot_cls[i]] < cap[slot_cls[i]]) begin
                        take = 1'b1;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (lane_free[l] && lane_cls(l) == slot_cls[i] &&
                                rank[l] == cnt[slot_cls[i]]) begin
                                lane_load[l] = 1'b1;
                                lane_op_d[l] = slot_op[i];
                            end
                        end
                        cnt[slot_cls[i]] += 1;
                        if (slot_cls[i] == CLS_TERM) terminate_d = 1'b1;
                    end
                end
                blocked = blocked | ~take;
                stopped = (slot_cls[i] == CLS_TERM);
            end
            instr_used[i] = take;
        end
    end

    // Flush beats load, load beats drain, a stalled lane holds.
    always_comb begin
        lane_valid_d = lane_valid_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (flush)             lane_valid_d[l] = 1'b0;
            else if (lane_load[l]) lane_valid_d[l] = 1'b1;
            else if (lane_ready[l]) lane_valid_d[l] = 1'b0;
        end
    end

    // NOTE: payload registers are reset as well, so no lane ever presents X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid_q <= '0;
            terminate_q  <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) lane_op_q[l] <= '0;
        end else begin
            lane_valid_q <= lane_valid_d;
            terminate_q  <= terminate_d;
            lane_op_q    <= lane_op_d;
        end
    end

    assign alu_valid  = lane_valid_q[ALU_LANES-1:0];
    assign mem_valid  = lane_valid_q[MEM_BASE +: MEM_LANES];
    assign term_valid = lane_valid_q[TERM_BASE +: TERM_LANES];
    assign terminate  = terminate_q;

    generate
        for (genvar l = 0; l < ALU_LANES; l++) begin : g_alu_out
            assign alu_op[l*OP_W +: OP_W] = lane_op_q[l];
        end
        for (genvar l = 0; l < MEM_LANES; l++) begin : g_mem_out
            assign mem_op[l*OP_W +: OP_W] = lane_op_q[MEM_BASE + l];
        end
        for (genvar l = 0; l < TERM_LANES; l++) begin : g_term_out
            assign term_op[l*OP_W +: OP_W] = lane_op_q[TERM_BASE + l];
        end
    endgenerate

endmodule
